simd_wave_controller: RTL and testbench
=======================================

// Module: simd_wave_controller
// PURPOSE
// - Sequences one SIMD unit through fetch/decode/execute for a single resident wavefront.
// - Drives the shared simd_state bus that the PC, per-lane RegisterFiles and LSUs key off.
// - Folds WAVE_SIZE threads onto LANE_WIDTH lanes by stepping curr_wave_cycle.
// - Generates the per-lane active mask for block/kernel tails and raises simd_done on RET.
// PARAMETERS
// - LANE_WIDTH  16  lanes per SIMD
// - WAVE_SIZE   32  threads per wavefront; TOTAL_WAVE_CYCLES = ceil(WAVE_SIZE/LANE_WIDTH)
// - CYC_W       max(1,$clog2(TOTAL_WAVE_CYCLES))  width of curr_wave_cycle
// PORTS
// - clk               in   1              rising-edge clock
// - rst               in   1              asynchronous reset, active-low (0 = reset)
// - enable            in   1              0 freezes all state; outputs hold
// - simd_start        in   1              dispatcher launches the wave (1-cycle pulse)
// - num_threads       in   32             kernel total thread count
// - block_dim         in   32             threads per block
// - block_id          in   32 signed      assigned block; negative = unassigned
// - wave_id           in   32 signed      assigned wave; negative = unassigned
// - instr_valid       in   1              fetcher has the instruction at pc_out
// - dec_mem_read      in   1              decoded instr is LOAD
// - dec_mem_write     in   1              decoded instr is STORE
// - dec_ret           in   1              decoded instr is RET
// - lsu_state         in   2*LANE_WIDTH   packed per-lane LSU state, lane i at [2i+1:2i]
// - simd_state        out  3              controller state broadcast
// - curr_wave_cycle   out  CYC_W          current lane-group within the wave
// - lane_active_mask  out  LANE_WIDTH     1 = lane holds a valid thread this wave cycle
// - fetch_req         out  1              request instruction fetch
// - pc_update         out  1              1-cycle pulse: advance PC
// - simd_done         out  1              wave retired
// BEHAVIOUR
// - Reset (async, rst=0): simd_state=IDLE, curr_wave_cycle=0, lane_active_mask=0.
//   fetch_req, pc_update and simd_done all reset to 0.
// - Registered FSM; all transitions are gated by enable=1.
//   - IDLE: simd_start goes to FETCH.
//   - FETCH: fetch_req=1 combinationally; instr_valid goes to DECODE, else hold.
//   - DECODE (1 cyc): dec_ret goes to DONE; else REQUEST, and lane_active_mask is loaded
//     for curr_wave_cycle.
//   - REQUEST (1 cyc) goes to WAIT.
//   - WAIT, non-memory instr (!dec_mem_read & !dec_mem_write): go to EXECUTE next cycle.
//   - WAIT, memory instr: hold until every lane with mask=1 reports lsu_state==LSU_DONE.
//     Lanes with mask=0 are ignored; mask==0 passes immediately.
//   - EXECUTE (1 cyc) goes to UPDATE.
//   - UPDATE, cycle < TOTAL_WAVE_CYCLES-1: cycle++, reload mask, go to REQUEST.
//   - UPDATE, last cycle: cycle=0, pulse pc_update for 1 clk, go to FETCH.
// - Latency, ALU instr with instr_valid already high: 2 + 4*TOTAL_WAVE_CYCLES clocks
//   from FETCH entry to the next FETCH entry.
// - DONE: simd_done=1 held. simd_start clears simd_done and goes to FETCH with cycle=0.
// - simd_start outside IDLE/DONE is ignored.
// - Mask: tid = wave_id*WAVE_SIZE + cycle*LANE_WIDTH + i; gid = block_id*block_dim + tid.
//   - Lane i is active iff tid < block_dim and gid < num_threads.
//   - Compute in 64-bit unsigned so there is no wrap.
//   - block_id<0 or wave_id<0 forces mask=0.
// - dec_* inputs are sampled only in DECODE/WAIT and must stay stable until FETCH.
// - Reset mid-operation: immediate IDLE; any in-flight LSU traffic is abandoned.
// STRUCTURE
// - simd_pkg: SIMD_IDLE..SIMD_DONE = 3'd0..3'd7 (IDLE, FETCH, DECODE, REQUEST, WAIT,
//   EXECUTE, UPDATE, DONE).
// - simd_pkg: LSU_IDLE/REQ/WAIT/DONE = 2'd0..3; TOTAL_WAVE_CYCLES function.
// - Sub-module simd_lane_mask (combinational tid/gid compare); controller registers its output.
// TESTING
// - Defaults; rst=0 mid-run -> every output 0 and simd_state=IDLE in the same cycle.
// - block_dim=32, num_threads=32, ids 0, ALU instr:
//   - simd_state goes 1,2,3,4,5,6,3,4,5,6,1.
//   - mask=FFFF for both cycles; pc_update pulses once.
// - block_dim=20, wave_id=0 -> mask FFFF at cycle0, 000F at cycle1.
// - num_threads=40, block_dim=32, block_id=1 -> cycle0 mask 00FF, cycle1 mask 0000.
//   - cycle1 WAIT exits in 1 clk even for a LOAD.
// - LOAD, mask FFFF, lane 3 reaches LSU_DONE 5 clks after the others -> WAIT lasts until lane 3.
//   - Forcing a masked-off lane to LSU_IDLE has no effect.
// - dec_ret -> DONE, simd_done=1.
//   - simd_start -> FETCH, simd_done=0.
//   - enable=0 for 3 clks mid-WAIT -> state and outputs frozen.

Source files
------------

// File: rtl/simd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | simd_pkg : state encodings and sizing helpers for the SIMD wave control  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package simd_pkg;

   typedef enum logic [2:0] {
      SIMD_IDLE    = 3'd0,
      SIMD_FETCH   = 3'd1,
      SIMD_DECODE  = 3'd2,
      SIMD_REQUEST = 3'd3,
      SIMD_WAIT    = 3'd4,
      SIMD_EXECUTE = 3'd5,
      SIMD_UPDATE  = 3'd6,
      SIMD_DONE    = 3'd7
   } simd_state_e;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_e;

   function automatic int total_wave_cycles(input int wave_size, input int lane_width);
      return (wave_size + lane_width - 1) / lane_width;
   endfunction

   function automatic int cyc_width(input int total_cycles);
      return (total_cycles > 1) ? $clog2(total_cycles) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/simd_lane_mask.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | simd_lane_mask : combinational per-lane thread-validity mask             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module simd_lane_mask #(
   parameter int LANE_WIDTH = 16,
   parameter int WAVE_SIZE  = 32,
   parameter int CYC_W      = 1
) (
   input  logic [31:0]            num_threads_i,
   input  logic [31:0]            block_dim_i,
   input  logic signed [31:0]     block_id_i,
   input  logic signed [31:0]     wave_id_i,
   input  logic [CYC_W-1:0]       wave_cycle_i,
   output logic [LANE_WIDTH-1:0]  mask_o
);

   logic [63:0] base_tid;
   logic [63:0] base_gid;
   logic [63:0] tid;
   logic [63:0] gid;

   // 64-bit products keep huge block_id*block_dim from wrapping into range
   always_comb begin
      base_tid = 64'(unsigned'(wave_id_i)) * 64'(WAVE_SIZE)
               + 64'(wave_cycle_i) * 64'(LANE_WIDTH);
      base_gid = 64'(unsigned'(block_id_i)) * 64'(block_dim_i);
      tid      = '0;
      gid      = '0;
      mask_o   = '0;
      for (int i = 0; i < LANE_WIDTH; i++) begin
         tid       = base_tid + 64'(i);
         gid       = base_gid + tid;
         mask_o[i] = (tid < 64'(block_dim_i)) && (gid < 64'(num_threads_i));
      end
      if (block_id_i < 0 || wave_id_i < 0) begin
         mask_o = '0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/simd_wave_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | simd_wave_controller : fetch/decode/execute sequencer for one wavefront  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module simd_wave_controller
   import simd_pkg::*;
#(
   parameter  int LANE_WIDTH        = 16,
   parameter  int WAVE_SIZE         = 32,
   localparam int TOTAL_WAVE_CYCLES = total_wave_cycles(WAVE_SIZE, LANE_WIDTH),
   localparam int CYC_W             = cyc_width(TOTAL_WAVE_CYCLES)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      simd_start,
   input  logic [31:0]               num_threads,
   input  logic [31:0]               block_dim,
   input  logic signed [31:0]        block_id,
   input  logic signed [31:0]        wave_id,
   input  logic                      instr_valid,
   input  logic                      dec_mem_read,
   input  logic                      dec_mem_write,
   input  logic                      dec_ret,
   input  logic [2*LANE_WIDTH-1:0]   lsu_state,
   output logic [2:0]                simd_state,
   output logic [CYC_W-1:0]          curr_wave_cycle,
   output logic [LANE_WIDTH-1:0]     lane_active_mask,
   output logic                      fetch_req,
   output logic                      pc_update,
   output logic                      simd_done
);

   localparam logic [CYC_W-1:0] C_LAST_CYCLE = CYC_W'(TOTAL_WAVE_CYCLES - 1);

   simd_state_e             state_q, state_d;
   logic [CYC_W-1:0]        cycle_q, cycle_d;
   logic [LANE_WIDTH-1:0]   mask_q, mask_d;
   logic [CYC_W-1:0]        w_mask_cycle;
   logic [LANE_WIDTH-1:0]   w_mask_calc;
   logic                    w_lanes_done;
   logic                    w_is_mem;

   // In UPDATE the mask is preloaded for the lane group about to start
   assign w_mask_cycle = (state_q == SIMD_UPDATE) ? cycle_q + 1'b1 : cycle_q;
   assign w_is_mem     = dec_mem_read | dec_mem_write;

   simd_lane_mask #(
      .LANE_WIDTH (LANE_WIDTH),
      .WAVE_SIZE  (WAVE_SIZE),
      .CYC_W      (CYC_W)
   ) u_lane_mask (
      .num_threads_i (num_threads),
      .block_dim_i   (block_dim),
      .block_id_i    (block_id),
      .wave_id_i     (wave_id),
      .wave_cycle_i  (w_mask_cycle),
      .mask_o        (w_mask_calc)
   );

   always_comb begin
      w_lanes_done = 1'b1;
      for (int i = 0; i < LANE_WIDTH; i++) begin
         if (mask_q[i] && (lsu_state[2*i +: 2] != LSU_DONE)) begin
            w_lanes_done = 1'b0;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cycle_d   = cycle_q;
      mask_d    = mask_q;
      fetch_req = 1'b0;
      pc_update = 1'b0;
      simd_done = 1'b0;
      case (state_q)
         SIMD_IDLE: begin
            if (simd_start) state_d = SIMD_FETCH;
         end
         SIMD_FETCH: begin
            fetch_req = 1'b1;
            if (instr_valid) state_d = SIMD_DECODE;
         end
         SIMD_DECODE: begin
            if (dec_ret) begin
               state_d = SIMD_DONE;
            end else begin
               state_d = SIMD_REQUEST;
               mask_d  = w_mask_calc;
            end
         end
         SIMD_REQUEST: begin
            state_d = SIMD_WAIT;
         end
         SIMD_WAIT: begin
            if (!w_is_mem || w_lanes_done) state_d = SIMD_EXECUTE;
         end
         SIMD_EXECUTE: begin
            state_d = SIMD_UPDATE;
         end
         SIMD_UPDATE: begin
            if (cycle_q != C_LAST_CYCLE) begin
               cycle_d = cycle_q + 1'b1;
               mask_d  = w_mask_calc;
               state_d = SIMD_REQUEST;
            end else begin
               cycle_d   = '0;
               pc_update = 1'b1;
               state_d   = SIMD_FETCH;
            end
         end
         SIMD_DONE: begin
            simd_done = 1'b1;
            if (simd_start) begin
               cycle_d = '0;
               state_d = SIMD_FETCH;
            end
         end
         default: begin
            state_d = SIMD_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= SIMD_IDLE;
         cycle_q <= '0;
         mask_q  <= '0;
      end else if (enable) begin
         state_q <= state_d;
         cycle_q <= cycle_d;
         mask_q  <= mask_d;
      end
   end

   assign simd_state       = state_q;
   assign curr_wave_cycle  = cycle_q;
   assign lane_active_mask = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_simd_wave_controller.sv
`default_nettype none
// Testbench for simd_wave_controller: directed scenarios plus randomized
// instructions checked against an arithmetic model of masks and latency.
module tb_simd_wave_controller;

   logic               clk = 1'b0;
   logic               rst;
   logic               enable;
   logic               simd_start;
   logic [31:0]        num_threads;
   logic [31:0]        block_dim;
   logic signed [31:0] block_id;
   logic signed [31:0] wave_id;
   logic               instr_valid;
   logic               dec_mem_read;
   logic               dec_mem_write;
   logic               dec_ret;
   logic [31:0]        lsu_state;
   logic [2:0]         simd_state;
   logic [0:0]         curr_wave_cycle;
   logic [15:0]        lane_active_mask;
   logic               fetch_req;
   logic               pc_update;
   logic               simd_done;

   int n_tests = 0;
   int n_fail  = 0;

   int          dly [2][16];
   int          obs_seq [$];
   logic [15:0] obs_mask [2];
   int          obs_wait [2];
   int          obs_cycles;
   int          obs_pcu;
   bit          obs_timeout;

   always #5 clk = ~clk;

   simd_wave_controller dut (
      .clk              (clk),
      .rst              (rst),
      .enable           (enable),
      .simd_start       (simd_start),
      .num_threads      (num_threads),
      .block_dim        (block_dim),
      .block_id         (block_id),
      .wave_id          (wave_id),
      .instr_valid      (instr_valid),
      .dec_mem_read     (dec_mem_read),
      .dec_mem_write    (dec_mem_write),
      .dec_ret          (dec_ret),
      .lsu_state        (lsu_state),
      .simd_state       (simd_state),
      .curr_wave_cycle  (curr_wave_cycle),
      .lane_active_mask (lane_active_mask),
      .fetch_req        (fetch_req),
      .pc_update        (pc_update),
      .simd_done        (simd_done)
   );

   // Reference: lane i valid iff its thread index is inside the block and the kernel
   function automatic logic [15:0] ref_mask(input logic [31:0] nt, input logic [31:0] bd,
                                            input int bid, input int wid, input int cyc);
      logic [15:0] m;
      longint unsigned tid, gid;
      m = '0;
      if (bid < 0 || wid < 0) return m;
      for (int i = 0; i < 16; i++) begin
         tid  = longint'(wid) * 32 + longint'(cyc) * 16 + longint'(i);
         gid  = longint'(bid) * longint'({32'd0, bd}) + tid;
         m[i] = (tid < {32'd0, bd}) && (gid < {32'd0, nt});
      end
      return m;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_delays();
      for (int g = 0; g < 2; g++)
         for (int i = 0; i < 16; i++) dly[g][i] = 0;
   endtask

   task automatic set_cfg(input int nt, input int bd, input int bid, input int wid);
      num_threads = nt;
      block_dim   = bd;
      block_id    = bid;
      wave_id     = wid;
   endtask

   // Reset, then launch: returns at a sample point with the DUT in FETCH
   task automatic start_wave();
      rst = 1'b0; enable = 1'b1; simd_start = 1'b0; instr_valid = 1'b0;
      dec_mem_read = 1'b0; dec_mem_write = 1'b0; dec_ret = 1'b0; lsu_state = '0;
      step();
      rst = 1'b1;
      simd_start = 1'b1;
      step();
      simd_start = 1'b0;
   endtask

   // Drives one instruction from FETCH to the next FETCH, recording observations.
   // Each active lane's LSU reports DONE after dly[group][lane] WAIT cycles.
   task automatic run_instr(input bit mem);
      int g = -1;
      int wcnt = 0;
      int k = 0;
      logic [15:0] am;
      obs_seq.delete();
      obs_pcu = 0; obs_timeout = 0;
      obs_wait[0] = 0; obs_wait[1] = 0;
      obs_mask[0] = 'x; obs_mask[1] = 'x;
      dec_mem_read = mem; dec_mem_write = 1'b0; dec_ret = 1'b0; instr_valid = 1'b1;
      forever begin
         obs_seq.push_back(int'(simd_state));
         if (pc_update) obs_pcu++;
         if (simd_state == 3'd3 && g < 1) begin
            g++;
            obs_mask[g] = lane_active_mask;
         end
         if (simd_state == 3'd4 && g >= 0) obs_wait[g]++;
         am = (g >= 0) ? ref_mask(num_threads, block_dim, block_id, wave_id, g) : 16'h0;
         for (int i = 0; i < 16; i++) begin
            if (!am[i])                                        lsu_state[2*i +: 2] = 2'd0;
            else if (simd_state == 3'd4 && wcnt >= dly[g][i])  lsu_state[2*i +: 2] = 2'd3;
            else                                               lsu_state[2*i +: 2] = 2'd2;
         end
         if (simd_state == 3'd4) wcnt++; else wcnt = 0;
         if (k > 0 && simd_state == 3'd1) break;
         if (k >= 200) begin obs_timeout = 1'b1; break; end
         k++;
         step();
      end
      obs_cycles = k;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      n_tests++; if (simd_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", simd_state); end
      n_tests++; if (curr_wave_cycle !== 1'b0) begin n_fail++; $display("FAIL reset_cycle: got %0d expected 0", curr_wave_cycle); end
      n_tests++; if (lane_active_mask !== 16'h0) begin n_fail++; $display("FAIL reset_mask: got %h expected 0000", lane_active_mask); end
      n_tests++; if ({fetch_req, pc_update, simd_done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {fetch_req, pc_update, simd_done}); end
      step();
      rst = 1'b1;
      step();
      n_tests++; if (simd_state !== 3'd0) begin n_fail++; $display("FAIL idle_hold: got %0d expected 0", simd_state); end
   endtask

   task automatic test_alu_full();
      int exp_seq [11];
      bit seq_ok;
      exp_seq = '{1, 2, 3, 4, 5, 6, 3, 4, 5, 6, 1};
      set_cfg(32, 32, 0, 0);
      clear_delays();
      start_wave();
      n_tests++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL alu_fetch_req: got %b expected 1", fetch_req); end
      run_instr(1'b0);
      seq_ok = (obs_seq.size() == 11);
      if (seq_ok) for (int i = 0; i < 11; i++) if (obs_seq[i] != exp_seq[i]) seq_ok = 0;
      n_tests++; if (!seq_ok) begin n_fail++; $display("FAIL alu_seq: got %p expected %p", obs_seq, exp_seq); end
      n_tests++; if (obs_mask[0] !== 16'hFFFF) begin n_fail++; $display("FAIL alu_mask0: got %h expected FFFF", obs_mask[0]); end
      n_tests++; if (obs_mask[1] !== 16'hFFFF) begin n_fail++; $display("FAIL alu_mask1: got %h expected FFFF", obs_mask[1]); end
      n_tests++; if (obs_pcu != 1) begin n_fail++; $display("FAIL alu_pc_update: got %0d pulses expected 1", obs_pcu); end
      n_tests++; if (obs_cycles != 10) begin n_fail++; $display("FAIL alu_latency: got %0d expected 10", obs_cycles); end
      n_tests++; if (curr_wave_cycle !== 1'b0) begin n_fail++; $display("FAIL alu_cycle_wrap: got %0d expected 0", curr_wave_cycle); end
   endtask

   task automatic test_block_tail();
      set_cfg(20, 20, 0, 0);
      clear_delays();
      start_wave();
      run_instr(1'b1);
      n_tests++; if (obs_mask[0] !== 16'hFFFF) begin n_fail++; $display("FAIL btail_mask0: got %h expected FFFF", obs_mask[0]); end
      n_tests++; if (obs_mask[1] !== 16'h000F) begin n_fail++; $display("FAIL btail_mask1: got %h expected 000F", obs_mask[1]); end
      n_tests++; if (obs_wait[1] != 1) begin n_fail++; $display("FAIL btail_masked_idle_wait: got %0d expected 1", obs_wait[1]); end
   endtask

   task automatic test_kernel_tail();
      set_cfg(40, 32, 1, 0);
      clear_delays();
      for (int i = 0; i < 16; i++) dly[0][i] = 2;
      start_wave();
      run_instr(1'b1);
      n_tests++; if (obs_mask[0] !== 16'h00FF) begin n_fail++; $display("FAIL ktail_mask0: got %h expected 00FF", obs_mask[0]); end
      n_tests++; if (obs_mask[1] !== 16'h0000) begin n_fail++; $display("FAIL ktail_mask1: got %h expected 0000", obs_mask[1]); end
      n_tests++; if (obs_wait[0] != 3) begin n_fail++; $display("FAIL ktail_wait0: got %0d expected 3", obs_wait[0]); end
      n_tests++; if (obs_wait[1] != 1) begin n_fail++; $display("FAIL ktail_wait1: got %0d expected 1", obs_wait[1]); end
   endtask

   task automatic test_load_skew();
      set_cfg(32, 32, 0, 0);
      clear_delays();
      dly[0][3] = 5;
      start_wave();
      run_instr(1'b1);
      n_tests++; if (obs_wait[0] != 6) begin n_fail++; $display("FAIL skew_wait0: got %0d expected 6", obs_wait[0]); end
      n_tests++; if (obs_wait[1] != 1) begin n_fail++; $display("FAIL skew_wait1: got %0d expected 1", obs_wait[1]); end
      n_tests++; if (obs_cycles != 15) begin n_fail++; $display("FAIL skew_latency: got %0d expected 15", obs_cycles); end
   endtask

   task automatic test_ret_done();
      set_cfg(32, 32, 0, 0);
      start_wave();
      step(); step();
      n_tests++; if (simd_state !== 3'd1 || fetch_req !== 1'b1) begin n_fail++; $display("FAIL fetch_hold: got state %0d req %b expected 1/1", simd_state, fetch_req); end
      simd_start = 1'b1;
      step();
      simd_start = 1'b0;
      n_tests++; if (simd_state !== 3'd1) begin n_fail++; $display("FAIL start_ignored: got %0d expected 1", simd_state); end
      instr_valid = 1'b1; dec_ret = 1'b1;
      step();
      n_tests++; if (simd_state !== 3'd2) begin n_fail++; $display("FAIL ret_decode: got %0d expected 2", simd_state); end
      step();
      n_tests++; if (simd_state !== 3'd7 || simd_done !== 1'b1) begin n_fail++; $display("FAIL ret_done: got state %0d done %b expected 7/1", simd_state, simd_done); end
      dec_ret = 1'b0;
      step(); step();
      n_tests++; if (simd_state !== 3'd7 || simd_done !== 1'b1) begin n_fail++; $display("FAIL done_hold: got state %0d done %b expected 7/1", simd_state, simd_done); end
      simd_start = 1'b1;
      step();
      simd_start = 1'b0;
      n_tests++; if (simd_state !== 3'd1 || simd_done !== 1'b0 || curr_wave_cycle !== 1'b0) begin n_fail++; $display("FAIL restart: got state %0d done %b cyc %0d expected 1/0/0", simd_state, simd_done, curr_wave_cycle); end
   endtask

   task automatic test_enable_freeze();
      set_cfg(32, 32, 0, 0);
      start_wave();
      instr_valid = 1'b1; dec_mem_read = 1'b1; lsu_state = {16{2'd2}};
      step(); step(); step();
      n_tests++; if (simd_state !== 3'd4) begin n_fail++; $display("FAIL freeze_enter_wait: got %0d expected 4", simd_state); end
      enable = 1'b0;
      lsu_state = {16{2'd3}};
      for (int j = 0; j < 3; j++) begin
         step();
         n_tests++;
         if (simd_state !== 3'd4 || lane_active_mask !== 16'hFFFF || curr_wave_cycle !== 1'b0 ||
             {fetch_req, pc_update, simd_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL freeze_%0d: got state %0d mask %h cyc %0d flags %b expected 4 FFFF 0 000",
                     j, simd_state, lane_active_mask, curr_wave_cycle, {fetch_req, pc_update, simd_done});
         end
      end
      enable = 1'b1;
      step();
      n_tests++; if (simd_state !== 3'd5) begin n_fail++; $display("FAIL freeze_release: got %0d expected 5", simd_state); end
      dec_mem_read = 1'b0;
   endtask

   task automatic test_reset_midrun();
      set_cfg(32, 32, 0, 0);
      start_wave();
      instr_valid = 1'b1;
      for (int j = 0; j < 6; j++) step();
      n_tests++; if (simd_state !== 3'd3 || curr_wave_cycle !== 1'b1) begin n_fail++; $display("FAIL midrun_pre: got state %0d cyc %0d expected 3/1", simd_state, curr_wave_cycle); end
      #2;
      rst = 1'b0;
      #1;
      n_tests++;
      if (simd_state !== 3'd0 || curr_wave_cycle !== 1'b0 || lane_active_mask !== 16'h0 ||
          {fetch_req, pc_update, simd_done} !== 3'b000) begin
         n_fail++;
         $display("FAIL midrun_reset: got state %0d cyc %0d mask %h flags %b expected all 0",
                  simd_state, curr_wave_cycle, lane_active_mask, {fetch_req, pc_update, simd_done});
      end
      rst = 1'b1;
      step();
   endtask

   task automatic test_random();
      logic [15:0] em;
      int exp_cycles, mx;
      bit mem;
      start_wave();
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 7) == 0)
            set_cfg(32'hFFFF_FFFF, 32'hFFFF_FFF0, $urandom_range(1, 3), $urandom_range(0, 1));
         else
            set_cfg($urandom_range(0, 150), $urandom_range(1, 48),
                    ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0) ? -2 : int'($urandom_range(0, 1)));
         for (int g = 0; g < 2; g++)
            for (int i = 0; i < 16; i++) dly[g][i] = $urandom_range(0, 4);
         mem = 1'($urandom_range(0, 1));
         run_instr(mem);
         exp_cycles = 2;
         for (int g = 0; g < 2; g++) begin
            em = ref_mask(num_threads, block_dim, block_id, wave_id, g);
            mx = 0;
            for (int i = 0; i < 16; i++) if (em[i] && dly[g][i] > mx) mx = dly[g][i];
            exp_cycles += 3 + (mem ? 1 + mx : 1);
            n_tests++; if (obs_mask[g] !== em) begin n_fail++; $display("FAIL rand%0d_mask%0d: got %h expected %h", it, g, obs_mask[g], em); end
         end
         n_tests++; if (obs_timeout || obs_cycles != exp_cycles) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, obs_cycles, exp_cycles); end
         n_tests++; if (obs_pcu != 1) begin n_fail++; $display("FAIL rand%0d_pc_update: got %0d expected 1", it, obs_pcu); end
         if (obs_timeout) break;
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; simd_start = 1'b0;
      num_threads = '0; block_dim = '0; block_id = '0; wave_id = '0;
      instr_valid = 1'b0; dec_mem_read = 1'b0; dec_mem_write = 1'b0; dec_ret = 1'b0;
      lsu_state = '0;
      clear_delays();
      test_reset();
      test_alu_full();
      test_block_tail();
      test_kernel_tail();
      test_load_skew();
      test_ret_done();
      test_enable_freeze();
      test_reset_midrun();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
